// File: rtl/mac_drain_pkg.sv
// mac_drain_pkg: shared widths, result type and round/saturate arithmetic for the MAC result drain.
package mac_drain_pkg;

    localparam int P_W       = 38;
    localparam int OUT_W     = 16;
    localparam int SHIFT_DEF = 10;

    typedef struct packed {
        logic                    sat;
        logic signed [OUT_W-1:0] data;
    } result_t;

    localparam logic signed [P_W:0] R_MAX = (P_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [P_W:0] R_MIN = (P_W+1)'(-(2**(OUT_W-1)));

    // One guard bit keeps the rounding add from overflowing at full-scale inputs.
    function automatic result_t round_sat(input logic signed [P_W-1:0] p, input int shift);
        logic signed [P_W:0] r;
        result_t res;
        r = ($signed({p[P_W-1], p}) + $signed((P_W+1)'(1) << (shift - 1))) >>> shift;
        res.sat  = (r > R_MAX) || (r < R_MIN);
        res.data = r > R_MAX ? R_MAX[OUT_W-1:0] : r < R_MIN ? R_MIN[OUT_W-1:0] : r[OUT_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/mac_drain_fifo.sv
// mac_drain_fifo: synchronous FIFO whose read port holds the last popped word while empty.
module mac_drain_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic [W-1:0] hold_q;
    logic full, wr_ok, rd_ok;

    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign rd_ok = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_ok = push & (~full | rd_ok);
    assign drop  = push & ~wr_ok;
    assign dout  = empty ? hold_q : mem[rp];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            hold_q <= '0;
        end else begin
            if (wr_ok) wp <= wp + 1'b1;
            if (rd_ok) rp <= rp + 1'b1;
            if (rd_ok) hold_q <= mem[rp];
            cnt <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end

endmodule

// File: rtl/mac_accum_result_drain.sv
// mac_accum_result_drain: counts MAC beats, rounds/saturates each window's accumulator and queues results.
module mac_accum_result_drain
    import mac_drain_pkg::*;
#(
    parameter int SHIFT      = SHIFT_DEF,
    parameter int ACC_LEN    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [P_W-1:0]   p_i,
    input  logic                    p_valid_i,
    output logic                    acc_clr_o,
    output logic signed [OUT_W-1:0] dout_o,
    output logic                    dout_sat_o,
    output logic                    dout_valid_o,
    input  logic                    dout_ready_i,
    output logic                    ovf_o
);

    localparam int CW = ACC_LEN > 1 ? $clog2(ACC_LEN) : 1;

    logic [CW-1:0] cnt;
    logic beat, last, pend, pop, empty, drop;
    result_t stage, head;

    // Beats arriving while the MAC is being cleared belong to no window.
    assign beat = p_valid_i & ~acc_clr_o;
    assign last = beat & (cnt == CW'(ACC_LEN - 1));
    assign pop  = dout_valid_o & dout_ready_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            acc_clr_o <= 1'b0;
            pend      <= 1'b0;
            stage     <= '0;
            ovf_o     <= 1'b0;
        end else begin
            if (beat) cnt <= last ? '0 : cnt + 1'b1;
            acc_clr_o <= last;
            pend      <= last;
            if (last) stage <= round_sat(p_i, SHIFT);
            ovf_o <= ovf_o | drop;
        end
    end

    mac_drain_fifo #(
        .W     ($bits(result_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pend),
        .din   (stage),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .drop  (drop)
    );

    assign dout_valid_o = ~empty;
    assign dout_o       = head.data;
    assign dout_sat_o   = head.sat;

endmodule

// File: tb/tb_mac_accum_result_drain.sv
// tb_mac_accum_result_drain: randomized and directed checks against a queue-based reference model.
module tb_mac_accum_result_drain;

    localparam int PW  = 38;
    localparam int ACC = 8;
    localparam int DEP = 4;
    localparam int SH  = 10;

    typedef struct {
        longint d;
        bit     s;
    } exp_t;

    logic clk = 0, reset = 0, valid = 0, ready = 0, ready1 = 1;
    logic signed [PW-1:0] p = '0;
    logic acc_clr, dvalid, dsat, ovf;
    logic signed [15:0] dout;
    logic acc_clr1, dvalid1, dsat1, ovf1;
    logic signed [15:0] dout1;
    int n_chk = 0, n_pass = 0;

    exp_t m_q[$];
    exp_t m_stage, m_last, e;
    int m_cnt = 0;
    bit m_clr = 0, m_pend = 0, m_ovf = 0;

    mac_accum_result_drain dut (
        .clk(clk), .reset(reset), .p_i(p), .p_valid_i(valid), .acc_clr_o(acc_clr),
        .dout_o(dout), .dout_sat_o(dsat), .dout_valid_o(dvalid), .dout_ready_i(ready), .ovf_o(ovf)
    );

    mac_accum_result_drain #(.ACC_LEN(1), .FIFO_DEPTH(2)) dut1 (
        .clk(clk), .reset(reset), .p_i(p), .p_valid_i(valid), .acc_clr_o(acc_clr1),
        .dout_o(dout1), .dout_sat_o(dsat1), .dout_valid_o(dvalid1), .dout_ready_i(ready1), .ovf_o(ovf1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic exp_t rr(input longint v);
        longint r;
        exp_t x;
        r = (v + (longint'(1) << (SH - 1))) >>> SH;
        x.d = r > 32767 ? 32767 : r < -32768 ? -32768 : r;
        x.s = r > 32767 || r < -32768;
        return x;
    endfunction

    function automatic longint rand_p();
        longint x;
        case ($urandom_range(0, 3))
            0: begin x = {$urandom, $urandom}; x = (x <<< 26) >>> 26; end
            1: x = longint'($urandom_range(0, 200000)) - 100000;
            2: x = longint'(32767 * 1024) + longint'($urandom_range(0, 2047)) - 1024;
            default: x = -longint'(32768 * 1024) + longint'($urandom_range(0, 2047)) - 1024;
        endcase
        return x;
    endfunction

    // Reference: windows of ACC accepted beats, results queued with DEP-entry capacity.
    initial forever begin
        bit nclr;
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_q.delete();
            m_last = '{0, 0};
            m_stage = '{0, 0};
            m_cnt = 0;
            m_clr = 0;
            m_pend = 0;
            m_ovf = 0;
        end else begin
            nclr = 0;
            if (ready && m_q.size() != 0) m_last = m_q.pop_front();
            if (m_pend) begin
                if (m_q.size() < DEP) m_q.push_back(m_stage);
                else m_ovf = 1;
            end
            m_pend = 0;
            if (valid && !m_clr) begin
                m_cnt++;
                if (m_cnt == ACC) begin
                    m_cnt = 0;
                    m_stage = rr(longint'(p));
                    m_pend = 1;
                    nclr = 1;
                end
            end
            m_clr = nclr;
        end
    end

    initial forever begin
        @(negedge clk);
        check("clr", acc_clr, m_clr);
        check("ovf", ovf, m_ovf);
        check("valid", dvalid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("data", dout, m_q[0].d);
            check("sat", dsat, m_q[0].s);
        end else begin
            check("hold", dout, m_last.d);
            check("hold_sat", dsat, m_last.s);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic feed(input longint v, input bit pop_e1);
        for (int i = 0; i < ACC; i++) begin
            p = PW'(i == ACC - 1 ? v : rand_p());
            valid = 1;
            @(negedge clk);
        end
        valid = 0;
        if (pop_e1) ready = 1;
        @(negedge clk);
        if (pop_e1) ready = 0;
    endtask

    task automatic win_chk(input string tag, input longint v, input longint ed, input longint es);
        feed(v, 0);
        check({tag, "_v"}, dvalid, 1);
        check({tag, "_d"}, dout, ed);
        check({tag, "_s"}, dsat, es);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_valid", dvalid, 0);
        check("rst_clr", acc_clr, 0);
        reset = 1;
        // reset mid-window with a result queued
        feed(3 * 1024, 0);
        check("t1_full", dvalid, 1);
        for (int i = 0; i < 3; i++) begin
            p = PW'(rand_p());
            valid = 1;
            @(negedge clk);
        end
        #2 reset = 0;
        #1;
        check("t1_dout", dout, 0);
        check("t1_valid", dvalid, 0);
        check("t1_sat", dsat, 0);
        check("t1_ovf", ovf, 0);
        check("t1_clr", acc_clr, 0);
        @(negedge clk);
        reset = 1;
        ready = 1;
        for (int i = 0; i < ACC - 1; i++) begin
            p = PW'(rand_p());
            valid = 1;
            @(negedge clk);
        end
        valid = 0;
        repeat (3) @(negedge clk);
        check("t1_seven", dvalid, 0);
        p = PW'(5120);
        valid = 1;
        @(negedge clk);
        check("t2_clr", acc_clr, 1);
        p = PW'(rand_p());
        @(negedge clk);
        valid = 0;
        check("t2_dout", dout, 5);
        check("t2_sat", dsat, 0);
        check("t2_valid", dvalid, 1);
        check("t2_clr1", acc_clr, 0);
        @(negedge clk);
        win_chk("r1536", 1536, 2, 0);
        win_chk("rm1536", -1536, -1, 0);
        win_chk("r511", 511, 0, 0);
        win_chk("r512", 512, 1, 0);
        win_chk("smax", (longint'(1) << 37) - 1, 32767, 1);
        win_chk("smin", -(longint'(1) << 37), -32768, 1);
        // overflow: five results, four slots
        ready = 0;
        for (int k = 1; k <= 5; k++) feed(k * 1024, 0);
        repeat (2) @(negedge clk);
        check("t5_ovf", ovf, 1);
        ready = 1;
        for (int k = 1; k <= 4; k++) begin
            check("t5_drain", dout, k);
            @(negedge clk);
        end
        check("t5_empty", dvalid, 0);
        check("t5_ovf_sticky", ovf, 1);
        // full FIFO with a pop coinciding with the push
        reset = 0;
        @(negedge clk);
        reset = 1;
        ready = 0;
        for (int k = 10; k <= 13; k++) feed(k * 1024, 0);
        feed(14 * 1024, 1);
        check("t6_ovf", ovf, 0);
        ready = 1;
        for (int k = 11; k <= 14; k++) begin
            check("t6_drain", dout, k);
            @(negedge clk);
        end
        check("t6_empty", dvalid, 0);
        // random traffic
        repeat (400) begin
            valid = $urandom_range(0, 9) < 7;
            p = PW'(rand_p());
            ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
        end
        valid = 0;
        ready = 1;
        repeat (8) @(negedge clk);
        // single-beat windows
        repeat (6) begin
            p = PW'(rand_p());
            e = rr(longint'(p));
            valid = 1;
            @(negedge clk);
            check("a1_clr", acc_clr1, 1);
            p = PW'(rand_p());
            @(negedge clk);
            check("a1_dout", dout1, e.d);
            check("a1_sat", dsat1, e.s);
            check("a1_valid", dvalid1, 1);
            check("a1_clr0", acc_clr1, 0);
            valid = 0;
            @(negedge clk);
            check("a1_empty", dvalid1, 0);
        end
        check("a1_ovf", ovf1, 0);
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
